// File: rtl/xrw_periph.sv
// Responder on the xctrl rw bus: 16-word register file plus a PS/2 scancode FIFO.
// The STATUS/DATA/CTRL registers sit at PS2_BASE. Define XRW_IRQ_EN to add the CTRL ie bit and the irq output.
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef INT_ADDR_W
`define INT_ADDR_W 8
`endif

module xrw_periph #(
  parameter int          REGF_ADDR_W = 4,
  parameter int unsigned REGF_BASE   = 0,
  parameter int unsigned PS2_BASE    = 'h40,
  parameter int          FIFO_AW     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rw_req,
  input  logic                   rw_rnw,
  input  logic [`INT_ADDR_W-1:0] rw_addr,
  input  logic [`DATA_W-1:0]     data_to_wr,
  output logic [`DATA_W-1:0]     data_to_rd,
  input  logic [7:0]             ps2_byte,
`ifdef XRW_IRQ_EN
  input  logic                   ps2_valid,
  output logic                   irq
`else
  input  logic                   ps2_valid
`endif
);

  localparam int          DW         = `DATA_W;
  localparam int          REGF_DEPTH = 2 ** REGF_ADDR_W;
  localparam int          FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int unsigned REGF_END   = REGF_BASE + REGF_DEPTH;

  logic [DW-1:0]          regf [REGF_DEPTH];
  logic [7:0]             fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0]       wr_ptr;
  logic [FIFO_AW:0]       rd_ptr;
  logic                   ovf;

  logic [31:0]            addr_ext;
  logic [REGF_ADDR_W-1:0] regf_idx;
  logic                   regf_hit;
  logic                   status_hit;
  logic                   data_hit;
  logic                   rd_cyc;
  logic                   wr_cyc;
  logic                   empty;
  logic                   full;
  logic                   do_pop;
  logic                   do_push;
  logic                   ovf_set;
  logic                   ovf_clr;
  logic [7:0]             head;

  assign addr_ext   = 32'(rw_addr);
  assign regf_hit   = (addr_ext >= REGF_BASE) && (addr_ext < REGF_END);
  assign regf_idx   = REGF_ADDR_W'(addr_ext - REGF_BASE);
  assign status_hit = (addr_ext == PS2_BASE);
  assign data_hit   = (addr_ext == PS2_BASE + 1);
  assign rd_cyc     = rw_req & rw_rnw;
  assign wr_cyc     = rw_req & ~rw_rnw;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head  = empty ? 8'h00 : fifo_mem[rd_ptr[FIFO_AW-1:0]];

  // A pop in the same cycle frees a slot, so a push on a full FIFO is only lost without one.
  assign do_pop  = rd_cyc & data_hit & ~empty;
  assign do_push = ps2_valid & (~full | do_pop);
  assign ovf_set = ps2_valid & full & ~do_pop;
  assign ovf_clr = wr_cyc & status_hit & data_to_wr[2];

`ifdef XRW_IRQ_EN
  logic ie;
  logic ctrl_hit;

  assign ctrl_hit = (addr_ext == PS2_BASE + 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_cyc && ctrl_hit) ie <= data_to_wr[0];
      irq <= ie & ~empty;
    end
  end
`endif

  always_comb begin
    data_to_rd = '0;
    if (rd_cyc) begin
      if (regf_hit)        data_to_rd = regf[regf_idx];
      else if (status_hit) data_to_rd = DW'({ovf, full, ~empty});
      else if (data_hit)   data_to_rd = DW'(head);
`ifdef XRW_IRQ_EN
      else if (ctrl_hit)   data_to_rd = DW'(ie);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGF_DEPTH; i++) regf[i] <= '0;
    end else if (wr_cyc && regf_hit) begin
      regf[regf_idx] <= data_to_wr;
    end
  end

  // Storage is not reset; reset empties the FIFO through the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= ps2_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule
